vertex_transform: RTL and testbench
===================================

# vertex_transform

Consumes the 4×4 view-projection matrix streamed column-by-column from the matrix generator and applies it to a stream of object-space vertices. Each accepted vertex (x, y, z) is extended to (x, y, z, 1.0), multiplied by the stored matrix using a single shared `fp32_dot` unit, and emitted as a clip-space 4-vector. The block sits between the matrix generator and the rasterizer front end in the graphics pipeline.

## Interface
- No parameters. Dot-product latency is taken from `fp32_dot` handshakes, not a parameter.
- `clk_in` in 1: system clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `mat_valid_in` in 1: matrix column beat valid. No ready; every beat is accepted.
- `mat_col_in` in [3:0][31:0]: fp32 column; beat k carries column k, element r = M[r][k].
- `valid_in` in 1: vertex valid.
- `ready_out` out 1: vertex accept.
- `pos_in` in [2:0][31:0]: fp32 vertex; [0]=x, [1]=y, [2]=z.
- `valid_out` out 1: result valid.
- `ready_in` in 1: downstream accept.
- `vec_out` out [3:0][31:0]: fp32 clip vector; [0]=x', [1]=y', [2]=z', [3]=w'.

## Operation
- Matrix load:
  - 2-bit beat counter `col_cnt` is reset to 0. Each `mat_valid_in` cycle writes column `col_cnt`, then increments it.
  - Beats need not be consecutive.
  - The 4th beat (wrap 3→0) completes the load and sets `mat_loaded`.
- Row extraction: row r = {col3[r], col2[r], col1[r], col0[r]}. Vertex operand = {32'h3F800000, z, y, x}.
- FSM states: `NoMatrix`, `Idle`, `Issue`, `Collect`, `Output`.
  - `NoMatrix`: `ready_out`=0. Goes to `Idle` when `mat_loaded` is set.
  - `Idle`: `ready_out`=1. On `valid_in`, latch `pos_in` and go to `Issue`.
  - `Issue`: 4 cycles. Drive `fp32_dot` `valid_in` with rows 0..3 in order against the latched operand. Then go to `Collect`.
  - `Collect`: capture `fp32_dot` results in arrival order into `vec_out[0..3]`. After the 4th result, go to `Output`.
  - `Output`: `valid_out`=1, with `vec_out` held stable. On `ready_in`, go to `Idle`.
- Only one vertex is in flight at a time. `ready_out`=0 in every state except `Idle`.
- Arithmetic is IEEE-754 single precision, inherited from `fp32_dot`. No NaN/Inf special handling beyond `fp32_dot`.

## Timing
- Reset values:
  - `valid_out`=0, `ready_out`=0, `vec_out`=0.
  - `col_cnt`=0, `mat_loaded`=0, state=`NoMatrix`.
- Reset mid-operation aborts any in-flight vertex or partial matrix load. Pending `fp32_dot` results are discarded: `fp32_dot` shares `rst_in`.
- Vertex accepted at cycle T (`valid_in`&&`ready_out`):
  - Issues occur at T+1..T+4.
  - With `fp32_dot` latency L, `valid_out` rises at T+5+L.
  - The earliest next accept is one cycle after the output handshake.
- `valid_out` stays high, with `vec_out` unchanged, until `ready_in`. A zero-wait handshake is allowed: `ready_in` already high in the first `Output` cycle.
- A matrix beat in the same cycle as a vertex accept: the beat is written, and the vertex uses the matrix selected per Configuration.

## Configuration
- `MATRIX_SHADOW_EN` defined:
  - Beats write a shadow matrix.
  - On completion of the 4th beat, the shadow commits to the active matrix. The commit happens immediately if state is `NoMatrix`/`Idle`/`Output`. Otherwise it is deferred until `Collect` exits.
  - A vertex always uses one complete, consistent matrix.
  - Partial loads never block `ready_out`.
- Not defined:
  - Beats write the active matrix directly.
  - While `col_cnt`≠0, `ready_out`=0.
  - Beats during `Issue` are a system-level precondition violation and give an undefined result for that vertex. The matrix generator loads only between frames.

## Structure
- Shared `graphics_pkg`:
  - `typedef logic [3:0][31:0] vec4_t`
  - `typedef logic [2:0][31:0] vec3_t`
  - `localparam FP32_ONE = 32'h3F800000`
- Sub-module: the existing `fp32_dot`, one instance. No new sub-module.

## Test plan
- Identity load (columns 3F800000 on the diagonal), vertex (1,2,3) = 3F800000/40000000/40400000 → `vec_out` = {3F800000, 40400000, 40000000, 3F800000}, arriving T+5+L after accept.
- Translation: col3 = {3F800000, 0, 0, 40A00000}, other columns identity; vertex (1,0,0) → x'=40C00000 (6.0), w'=3F800000.
- No matrix after reset: hold `valid_in`=1 for 50 cycles → `ready_out`=0 and `valid_out`=0 throughout. After 4 beats, `ready_out`=1 the next cycle.
- Backpressure: `ready_in`=0 for 10 cycles in `Output` → `valid_out` stays 1, `vec_out` stays stable, `ready_out` stays 0. Raise `ready_in` → `valid_out`=0 and `ready_out`=1 the next cycle.
- With `MATRIX_SHADOW_EN`: identity is active; accept vertex (1,2,3); stream a 2.0-scale matrix during `Issue` → the result is the identity result. The next vertex gives {3F800000, 40C00000, 40800000, 40000000}.
- Assert `rst_in` during `Collect` → all outputs return to reset values asynchronously. After reload and a new vertex, no stale result appears.

Source files
------------

// File: rtl/graphics_pkg.sv
// Types and constants shared across the graphics pipeline blocks.
package graphics_pkg;
  typedef logic [3:0][31:0] vec4_t;
  typedef logic [2:0][31:0] vec3_t;
  localparam logic [31:0] FP32_ONE = 32'h3F800000;

  typedef enum logic [2:0] {
    NoMatrix,
    Idle,
    Issue,
    Collect,
    Output
  } vt_state_t;
endpackage

// File: rtl/fp32_dot.sv
// Pipelined fp32 4-element dot product: multiply, pairwise add, final add (latency 3).
// Denormals flush to zero, overflow saturates to infinity, rounding is nearest-even.
module fp32_dot
  import graphics_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  vec4_t       a_in,
  input  vec4_t       b_in,
  output logic        valid_out,
  output logic [31:0] result_out
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic        [47:0] p;
    logic        [24:0] m;
    logic signed [9:0]  e;
    logic               rnd;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    if (p[47]) begin
      rnd = p[23] & ((|p[22:0]) | p[24]);
      m   = {1'b0, p[47:24]} + {24'b0, rnd};
      e   = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd126;
    end else begin
      rnd = p[22] & ((|p[21:0]) | p[23]);
      m   = {1'b0, p[46:23]} + {24'b0, rnd};
      e   = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
    end
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0) return {s, 31'b0};
    if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        [31:0] x, y;
    logic        [7:0]  d;
    logic        [27:0] mx, my, s, mask;
    logic signed [9:0]  e;
    logic        [24:0] r;
    logic               st, rnd;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'h0 : b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b0, 1'b1, x[22:0], 3'b0};
    my = {1'b0, 1'b1, y[22:0], 3'b0};
    // Alignment keeps every shifted-out bit as a sticky bit for rounding.
    if (d > 8'd26) begin
      my = 28'd1;
    end else begin
      mask = ~(28'hFFFFFFF << d);
      st   = |(my & mask);
      my   = (my >> d) | {27'b0, st};
    end
    s = (x[31] == y[31]) ? mx + my : mx - my;
    if (s == 28'd0) return 32'h0;
    e = $signed({2'b0, x[30:23]});
    if (s[27]) begin
      s = {1'b0, s[27:1]} | {27'b0, s[0]};
      e = e + 10'sd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!s[26]) begin
        s = s << 1;
        e = e - 10'sd1;
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    r   = {1'b0, s[26:3]} + {24'b0, rnd};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0) return {x[31], 31'b0};
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'b0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  vec4_t             prod_p0;
  logic [1:0][31:0]  sum_p1;
  logic [31:0]       res_p2;
  logic              vld_p0, vld_p1, vld_p2;

  always_ff @(posedge clk_in) begin
    // p0: element products
    for (int i = 0; i < 4; i++) prod_p0[i] <= fp_mul(a_in[i], b_in[i]);
    // p1: pairwise sums
    sum_p1[0] <= fp_add(prod_p0[0], prod_p0[1]);
    sum_p1[1] <= fp_add(prod_p0[2], prod_p0[3]);
    // p2: final sum
    res_p2    <= fp_add(sum_p1[0], sum_p1[1]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= valid_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  assign valid_out  = vld_p2;
  assign result_out = res_p2;

endmodule

// File: rtl/vertex_transform.sv
// Applies a streamed 4x4 matrix to object-space vertices through one shared fp32_dot.
// Define MATRIX_SHADOW_EN to double-buffer the matrix so loads can overlap vertex work.
module vertex_transform
  import graphics_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  mat_valid_in,
  input  vec4_t mat_col_in,
  input  logic  valid_in,
  output logic  ready_out,
  input  vec3_t pos_in,
  output logic  valid_out,
  input  logic  ready_in,
  output vec4_t vec_out
);

  vt_state_t   state_q, state_d;
  logic [1:0]  col_cnt_q, iss_cnt_q, res_cnt_q;
  logic        mat_loaded_q;
  vec4_t       act_q [4];
  vec3_t       pos_q;
  vec4_t       vec_q;
  vec4_t       row, operand;
  logic        load_done, accept, ld_ok, dot_valid, dot_vld;
  logic [31:0] dot_res;

  assign load_done = mat_valid_in && (col_cnt_q == 2'd3);
  assign accept    = valid_in && ready_out;

  always_comb begin
    row = '0;
    for (int k = 0; k < 4; k++) row[k] = act_q[k][iss_cnt_q];
    operand = {FP32_ONE, pos_q[2], pos_q[1], pos_q[0]};
  end

`ifdef MATRIX_SHADOW_EN
  vec4_t shd_q [4];
  logic  pend_q, commit_ok;

  // Only swap matrices while no vertex is between its first issue and last result.
  assign commit_ok = (state_q == NoMatrix) || (state_q == Idle) || (state_q == Output);
  assign ld_ok     = 1'b1;

  always_ff @(posedge clk_in) begin
    if (mat_valid_in) shd_q[col_cnt_q] <= mat_col_in;
    if (load_done && commit_ok) begin
      for (int k = 0; k < 3; k++) act_q[k] <= shd_q[k];
      act_q[3] <= mat_col_in;
    end else if (pend_q && commit_ok && col_cnt_q == 2'd0) begin
      act_q <= shd_q;
    end
    if (accept) pos_q <= pos_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) pend_q <= 1'b0;
    else if (load_done) pend_q <= !commit_ok;
    else if (pend_q && commit_ok && col_cnt_q == 2'd0) pend_q <= 1'b0;
  end
`else
  assign ld_ok = (col_cnt_q == 2'd0);

  always_ff @(posedge clk_in) begin
    if (mat_valid_in) act_q[col_cnt_q] <= mat_col_in;
    if (accept) pos_q <= pos_in;
  end
`endif

  fp32_dot u_dot (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (dot_valid),
    .a_in      (row),
    .b_in      (operand),
    .valid_out (dot_vld),
    .result_out(dot_res)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= NoMatrix;
      col_cnt_q    <= 2'd0;
      mat_loaded_q <= 1'b0;
      iss_cnt_q    <= 2'd0;
      res_cnt_q    <= 2'd0;
      vec_q        <= '0;
    end else begin
      state_q <= state_d;
      if (mat_valid_in) col_cnt_q <= col_cnt_q + 2'd1;
      if (load_done) mat_loaded_q <= 1'b1;
      if (state_q == Issue) iss_cnt_q <= iss_cnt_q + 2'd1;
      if (dot_vld && (state_q == Issue || state_q == Collect)) begin
        vec_q[res_cnt_q] <= dot_res;
        res_cnt_q        <= res_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
    dot_valid = 1'b0;
    case (state_q)
      NoMatrix: if (mat_loaded_q || load_done) state_d = Idle;
      Idle: begin
        ready_out = ld_ok;
        if (valid_in && ld_ok) state_d = Issue;
      end
      Issue: begin
        dot_valid = 1'b1;
        if (iss_cnt_q == 2'd3) state_d = Collect;
      end
      Collect: if (dot_vld && res_cnt_q == 2'd3) state_d = Output;
      Output: begin
        valid_out = 1'b1;
        if (ready_in) state_d = Idle;
      end
      default: state_d = NoMatrix;
    endcase
  end

  assign vec_out = vec_q;

endmodule

// File: tb/tb_vertex_transform.sv
// Scoreboard bench for vertex_transform using an integer-valued matrix/vertex reference model.
module tb_vertex_transform;
  import graphics_pkg::*;

  localparam int DOT_L = 3;

  logic  clk = 1'b0;
  logic  rst;
  logic  mat_valid_in;
  vec4_t mat_col_in;
  logic  valid_in;
  logic  ready_out;
  vec3_t pos_in;
  logic  valid_out;
  logic  ready_in = 1'b1;
  vec4_t vec_out;

  vertex_transform dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .mat_valid_in(mat_valid_in),
    .mat_col_in  (mat_col_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .pos_in      (pos_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .vec_out     (vec_out)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    last_acc = 0;
  vec4_t exp_q[$];
  int    acc_q[$];
  int    am[4][4];
  int    nm[4][4];
  logic  rnd_rdy = 1'b0;
  logic  rdy_force = 1'b1;
  logic  prev_vo = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    ready_in = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [31:0] int2fp(input int v);
    int          mag;
    int          msb;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    msb = 0;
    for (int b = 0; b < 24; b++) if (mag[b]) msb = b;
    m = 32'(mag) << (23 - msb);
    return {(v < 0), 8'(127 + msb), m[22:0]};
  endfunction

  // Clip vector = M * (x, y, z, 1) in exact integer arithmetic, then encoded.
  function automatic vec4_t model(input int x, input int y, input int z);
    int    v[4];
    int    s;
    vec4_t res;
    v = '{x, y, z, 1};
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += am[r][k] * v[k];
      res[r] = int2fp(s);
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_vo = 1'b0;
    end else begin
      if (valid_out && !prev_vo) begin
        if (acc_q.size() == 0) timeout("latency_no_accept");
        else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(5 + DOT_L));
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result actual=%h required=none", vec_out);
        end else begin
          chk("vec_out", vec_out, exp_q.pop_front());
        end
      end
      prev_vo = valid_out;
    end
  end

  task automatic set_identity();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) nm[r][k] = (r == k) ? 1 : 0;
  endtask

  task automatic load_matrix(input bit gaps);
    for (int k = 0; k < 4; k++) begin
      mat_col_in   = {int2fp(nm[3][k]), int2fp(nm[2][k]), int2fp(nm[1][k]), int2fp(nm[0][k])};
      mat_valid_in = 1'b1;
      @(posedge clk);
      #1;
      mat_valid_in = 1'b0;
      if (gaps && k < 3 && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    am = nm;
  endtask

  task automatic send_vertex(input int x, input int y, input int z);
    bit ok;
    ok       = 1'b0;
    valid_in = 1'b1;
    pos_in   = {int2fp(z), int2fp(y), int2fp(x)};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back(model(x, y, z));
      acc_q.push_back(cyc);
      last_acc = cyc;
    end else begin
      timeout("vertex_accept");
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit    seen;
    vec4_t snap;
    rst          = 1'b1;
    mat_valid_in = 1'b0;
    mat_col_in   = '0;
    valid_in     = 1'b0;
    pos_in       = '0;
    #1;
    chk("reset_valid_out", 128'(valid_out), 128'(0));
    chk("reset_ready_out", 128'(ready_out), 128'(0));
    chk("reset_vec_out", vec_out, 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    valid_in = 1'b1;
    pos_in   = {int2fp(3), int2fp(2), int2fp(1)};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("nomatrix_ready_out", 128'(ready_out), 128'(0));
      chk("nomatrix_valid_out", 128'(valid_out), 128'(0));
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;

    set_identity();
    load_matrix(1'b1);
    @(negedge clk);
    chk("ready_after_load", 128'(ready_out), 128'(1));
    @(posedge clk);
    #1;
    send_vertex(1, 2, 3);
    wait_drain();

    set_identity();
    nm[0][3] = 5;
    load_matrix(1'b0);
    send_vertex(1, 0, 0);
    wait_drain();

    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    send_vertex(2, 3, 4);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("backpressure_valid");
    snap = vec_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_out", 128'(valid_out), 128'(1));
      chk("bp_vec_stable", vec_out, snap);
      chk("bp_ready_out", 128'(ready_out), 128'(0));
    end
    rdy_force = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid_out", 128'(valid_out), 128'(0));
    chk("bp_release_ready_out", 128'(ready_out), 128'(1));
    wait_drain();

    rnd_rdy = 1'b1;
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++) nm[r][k] = int'($urandom_range(0, 16)) - 8;
      load_matrix(1'b1);
      for (int i = 0; i < 5; i++)
        send_vertex(int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8,
                    int'($urandom_range(0, 16)) - 8);
      wait_drain();
    end
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef MATRIX_SHADOW_EN
    set_identity();
    load_matrix(1'b0);
    send_vertex(1, 2, 3);
    set_identity();
    nm[0][0] = 2;
    nm[1][1] = 2;
    nm[2][2] = 2;
    load_matrix(1'b0);
    wait_drain();
    send_vertex(1, 2, 3);
    wait_drain();
`endif

    set_identity();
    load_matrix(1'b0);
    send_vertex(1, 2, 3);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc >= last_acc + 6) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("collect_wait");
    rst = 1'b1;
    #1;
    chk("midreset_valid_out", 128'(valid_out), 128'(0));
    chk("midreset_ready_out", 128'(ready_out), 128'(0));
    chk("midreset_vec_out", vec_out, 128'(0));
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postreset_ready_out", 128'(ready_out), 128'(0));
    @(posedge clk);
    #1;
    set_identity();
    nm[1][3] = 7;
    load_matrix(1'b0);
    send_vertex(4, 5, 6);
    wait_drain();
    repeat (20) @(posedge clk);
    chk("postreset_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
